// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V controller and its datapath:
// state codes, opcode and funct3 constants, ALU operation codes, control bundle.
package multi_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic    pc_write;
    logic    pc_src;
    logic    ir_write;
    logic    mem_read;
    logic    mem_write;
    logic    i_or_d;
    logic    alu_src;
    logic    reg_write;
    logic    mem_to_reg;
    alu_op_e alu_op;
    logic    halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic opcode_supported(input logic [6:0] opcode);
    return opcode inside {OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE, OPC_BRANCH};
  endfunction

  // Only BEQ and BNE are decoded; every other funct3 falls through untaken.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
    return ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts stalled cycles in FETCH/MEM and flags the timeout
// cycle, i.e. the cycle where the count has reached the limit and memory is still busy.
module mc_wait_timer
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);

  localparam logic [3:0] LIMIT = 4'(TIMEOUT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      wait_cnt_d = '0;
    end else if (waiting && (wait_cnt_q != LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout = waiting && (wait_cnt_q == LIMIT);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32 control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, decodes the
// datapath controls from the registered state and the IR, and counts retired instructions.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        alu_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  ctrl_t       ctrl;
  logic        retire;
  logic        waiting;
  logic        timer_clear;
  logic        timeout;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_store;
  logic       is_load;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_store = (opcode == OPC_STORE);
  assign is_load  = (opcode == OPC_LOAD);

  always_comb begin
    state_d = state_q;
    ctrl    = CTRL_IDLE;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
          state_d       = S_DECODE;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        state_d = opcode_supported(opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode)
          OPC_RTYPE: begin
            ctrl.alu_op = ALU_RTYPE;
            state_d     = S_WB;
          end
          OPC_ITYPE: begin
            ctrl.alu_op  = ALU_ITYPE;
            ctrl.alu_src = 1'b1;
            state_d      = S_WB;
          end
          OPC_LOAD, OPC_STORE: begin
            ctrl.alu_op  = ALU_ADD;
            ctrl.alu_src = 1'b1;
            state_d      = S_MEM;
          end
          OPC_BRANCH: begin
            ctrl.alu_op   = ALU_BRANCH;
            ctrl.pc_write = branch_taken(funct3, zero);
            ctrl.pc_src   = branch_taken(funct3, zero);
            retire        = 1'b1;
            state_d       = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = is_store;
        ctrl.mem_read  = !is_store;
        if (mem_ready) begin
          retire  = is_store;
          state_d = is_store ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        ctrl.reg_write  = is_load;
        ctrl.mem_to_reg = is_load;
        retire          = 1'b1;
        state_d         = S_FETCH;
      end
      S_TRAP: begin
        ctrl.halted = 1'b1;
      end
      // Codes 6 and 7 are unreachable in normal operation; treat them as faults.
      default: state_d = S_TRAP;
    endcase
  end

  // The timer restarts whenever a memory-access state is entered from elsewhere.
  assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign timer_clear = ((state_d == S_FETCH) || (state_d == S_MEM)) && (state_d != state_q);
  assign instret_d   = retire ? instret_q + 32'd1 : instret_q;

  mc_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .waiting(waiting),
    .timeout(timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign pc_write   = ctrl.pc_write;
  assign pc_src     = ctrl.pc_src;
  assign ir_write   = ctrl.ir_write;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign i_or_d     = ctrl.i_or_d;
  assign alu_src    = ctrl.alu_src;
  assign reg_write  = ctrl.reg_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_op     = ctrl.alu_op;
  assign halted     = ctrl.halted;
  assign state      = state_q;
  assign instret    = instret_q;

  // Immediate and register fields belong to the datapath, not the controller.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: an instruction-level model expands each instruction
// into its expected per-cycle trace; a compare process checks every cycle.
module tb_multi_cycle_ctrl;

  localparam int TO = 15;

  // Expected control vector bit positions:
  // {pc_write,pc_src,ir_write,mem_read,mem_write,i_or_d,alu_src,reg_write,mem_to_reg,alu_op[1:0],halted}
  localparam logic [11:0] C_PCW  = 12'h800;
  localparam logic [11:0] C_PCS  = 12'h400;
  localparam logic [11:0] C_IRW  = 12'h200;
  localparam logic [11:0] C_MRD  = 12'h100;
  localparam logic [11:0] C_MWR  = 12'h080;
  localparam logic [11:0] C_IOD  = 12'h040;
  localparam logic [11:0] C_ASRC = 12'h020;
  localparam logic [11:0] C_RW   = 12'h010;
  localparam logic [11:0] C_M2R  = 12'h008;
  localparam logic [11:0] C_AL_R = 12'h004;
  localparam logic [11:0] C_AL_I = 12'h006;
  localparam logic [11:0] C_AL_B = 12'h002;
  localparam logic [11:0] C_HALT = 12'h001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d;
  logic        alu_src, reg_write, mem_to_reg, halted;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst      (inst),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .i_or_d    (i_or_d),
    .alu_src   (alu_src),
    .reg_write (reg_write),
    .mem_to_reg(mem_to_reg),
    .alu_op    (alu_op),
    .state     (state),
    .halted    (halted),
    .instret   (instret)
  );

  logic [11:0] ctrl_obs;
  assign ctrl_obs = {pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
                     alu_src, reg_write, mem_to_reg, alu_op, halted};

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_valid = 1'b0;
  logic [2:0]  exp_st;
  logic [11:0] exp_ctrl;
  logic [31:0] exp_ir;
  logic [31:0] m_instret = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      check("state", {29'd0, state}, {29'd0, exp_st});
      check("ctrl", {20'd0, ctrl_obs}, {20'd0, exp_ctrl});
      check("instret", instret, exp_ir);
    end
  end

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // One clock cycle of stimulus with the outputs that cycle must show.
  task automatic step(input bit r, input logic [31:0] i, input bit z, input bit rd,
                      input logic [2:0] st, input logic [11:0] c, input bit ret);
    @(negedge clk);
    rst       = r;
    inst      = i;
    zero      = z;
    mem_ready = rd;
    exp_st    = st;
    exp_ctrl  = c;
    exp_ir    = m_instret;
    exp_valid = 1'b1;
    if (r) m_instret = '0;
    else if (ret) m_instret = m_instret + 32'd1;
  endtask

  // 0 R, 1 I, 2 load, 3 store, 4 branch, 5 unsupported
  function automatic int classify(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return 4;
      default:    return 5;
    endcase
  endfunction

  // Memory answers after w busy cycles; w > TO means it never answers in time.
  task automatic fetch(input int w, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      if (k == w) begin
        step(0, $urandom, rb(), 1, 3'd0, C_MRD | C_IRW | C_PCW, 0);
        ok = 1'b1;
        break;
      end
      step(0, $urandom, rb(), 0, 3'd0, C_MRD, 0);
    end
  endtask

  task automatic trap_and_reset(input int n);
    for (int k = 0; k < n; k++) step(0, $urandom, rb(), rb(), 3'd5, C_HALT, 0);
    step(1, $urandom, rb(), rb(), 3'd5, C_HALT, 0);
  endtask

  task automatic run_inst(input logic [31:0] ins, input bit z, input int fw, input int mw,
                          input bit abort);
    bit ok;
    int k;
    logic [11:0] base;
    logic [2:0] f3;
    k  = classify(ins[6:0]);
    f3 = ins[14:12];
    fetch(fw, ok);
    if (!ok) begin
      trap_and_reset(3);
      return;
    end
    step(0, ins, rb(), rb(), 3'd1, 12'h000, 0);
    case (k)
      0, 1: begin
        step(0, ins, rb(), rb(), 3'd2, (k == 0) ? C_AL_R : (C_AL_I | C_ASRC), 0);
        step(0, ins, rb(), rb(), 3'd4, 12'h000, 1);
      end
      4: begin
        bit tk;
        tk = ((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z);
        step(0, ins, z, rb(), 3'd2, C_AL_B | (tk ? (C_PCW | C_PCS) : 12'h000), 1);
      end
      2, 3: begin
        step(0, ins, rb(), rb(), 3'd2, C_ASRC, 0);
        base = C_IOD | C_ASRC | ((k == 2) ? C_MRD : C_MWR);
        if (abort) begin
          step(1, ins, rb(), 1, 3'd3, base, 0);
          return;
        end
        ok = 1'b0;
        for (int j = 0; j <= TO; j++) begin
          if (j == mw) begin
            step(0, ins, rb(), 1, 3'd3, base, k == 3);
            ok = 1'b1;
            break;
          end
          step(0, ins, rb(), 0, 3'd3, base, 0);
        end
        if (!ok) trap_and_reset(2);
        else if (k == 2) step(0, ins, rb(), rb(), 3'd4, C_RW | C_M2R, 1);
      end
      default: trap_and_reset(2);
    endcase
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 31);
    if (r < 20) return 0;
    if (r < 30) return $urandom_range(1, TO);
    if (r == 30) return TO;
    return TO + 1;
  endfunction

  initial begin
    bit ok;
    logic [31:0] ins;
    logic [6:0] op;
    int sel;

    // First reset edge brings the DUT out of X; checking starts the cycle after.
    @(negedge clk);
    rst = 1'b1;
    step(1, 32'h0, 0, 0, 3'd0, C_MRD, 0);

    // add x3,x1,x2: states 0,1,2,4 then back to 0
    run_inst(32'h002081B3, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("add_instret", instret, 32'd1);
    check("add_back_to_fetch", {29'd0, state}, 32'd0);

    // lw x5,0(x1) with three busy memory cycles
    run_inst(32'h0000A283, 0, 0, 3, 0);
    @(posedge clk); #1;
    check("lw_instret", instret, 32'd2);

    // beq taken, bne not taken with zero=1
    run_inst(32'h00208463, 1, 0, 0, 0);
    run_inst(32'h00209463, 1, 0, 0, 0);
    @(posedge clk); #1;
    check("branch_instret", instret, 32'd4);

    // lui is unsupported: trap after DECODE, then reset
    fetch(0, ok);
    step(0, 32'h000000B7, 0, 0, 3'd1, 12'h000, 0);
    @(posedge clk); #1;
    check("lui_trap_state", {29'd0, state}, 32'd5);
    check("lui_halted", {31'd0, halted}, 32'd1);
    trap_and_reset(3);
    @(posedge clk); #1;
    check("trap_reset_state", {29'd0, state}, 32'd0);
    check("trap_reset_instret", instret, 32'd0);

    // FETCH never answered: TRAP 16 cycles after entry
    fetch(TO + 1, ok);
    @(posedge clk); #1;
    check("fetch_timeout_state", {29'd0, state}, 32'd5);
    trap_and_reset(1);

    // Ready exactly at the limit count wins over the timeout
    run_inst(32'h002081B3, 0, TO, 0, 0);
    run_inst(32'h0020A023, 0, 0, TO, 0);
    @(posedge clk); #1;
    check("limit_ready_instret", instret, 32'd2);

    // instret wrap on a store retire
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    run_inst(32'h0020A023, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("instret_wrap", instret, 32'd0);

    // Reset in MEM of a store with mem_ready pending abandons the access
    run_inst(32'h0020A023, 0, 1, 0, 1);
    @(posedge clk); #1;
    check("abort_mem_write", {31'd0, mem_write}, 32'd0);
    check("abort_state", {29'd0, state}, 32'd0);
    check("abort_instret", instret, 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 19);
      if (sel < 4) op = 7'b0110011;
      else if (sel < 8) op = 7'b0010011;
      else if (sel < 12) op = 7'b0000011;
      else if (sel < 16) op = 7'b0100011;
      else if (sel < 19) op = 7'b1100011;
      else begin
        op = 7'($urandom);
        while (classify(op) != 5) op = 7'($urandom);
      end
      ins = $urandom;
      ins[6:0] = op;
      run_inst(ins, rb(), rand_wait(), rand_wait(), $urandom_range(0, 29) == 0);
    end

    @(negedge clk);
    exp_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
